// File: rtl/pipe_mux_n.sv
// ============================================================================
//  Module      : pipe_mux_n
//  Description : N-to-1 channel select feeding a two-entry skid buffer with
//                registered in_ready and a saturating bad-select counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_mux_n #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_sel_err,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         err_cnt
);

    localparam bit c_N_IS_POW2 = ((N & (N - 1)) == 0);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_main_data;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_main_err;
    logic             r_skid_err;
    logic             r_in_ready;
    logic [7:0]       r_err_cnt;

    logic [WIDTH-1:0] w_sel_data;
    logic             w_sel_err;
    logic             w_accept;
    logic             w_drain;
    logic             w_load_main;
    logic             w_load_skid;
    logic             w_skid_to_main;

    // Out-of-range selects fall back to channel 0.
    always_comb begin
        w_sel_data = in_data[WIDTH-1:0];
        for (int k = 1; k < N; k++) begin
            if (in_sel == SEL_W'(k)) begin
                w_sel_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    if (c_N_IS_POW2) begin : g_sel_pow2
        assign w_sel_err = 1'b0;
    end else begin : g_sel_range
        assign w_sel_err = ({{(32-SEL_W){1'b0}}, in_sel} >= 32'(N));
    end

    assign w_accept = in_valid && r_in_ready;
    assign w_drain  = out_valid && out_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ST_ONE;
                    w_load_main = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && !w_drain) begin
                    w_state_nxt = ST_TWO;
                    w_load_skid = 1'b1;
                end else if (!w_accept && w_drain) begin
                    w_state_nxt = ST_EMPTY;
                end else if (w_accept && w_drain) begin
                    w_load_main = 1'b1;
                end
            end
            ST_TWO: begin
                if (w_drain) begin
                    w_state_nxt    = ST_ONE;
                    w_skid_to_main = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
        if (flush) begin
            w_state_nxt    = ST_EMPTY;
            w_load_main    = 1'b0;
            w_load_skid    = 1'b0;
            w_skid_to_main = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_main_data <= '0;
            r_main_err  <= 1'b0;
            r_skid_data <= '0;
            r_skid_err  <= 1'b0;
            r_err_cnt   <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            // Ready is derived from the next state so it never waits on out_ready.
            r_in_ready <= (w_state_nxt != ST_TWO);
            if (w_load_main) begin
                r_main_data <= w_sel_data;
                r_main_err  <= w_sel_err;
            end else if (w_skid_to_main) begin
                r_main_data <= r_skid_data;
                r_main_err  <= r_skid_err;
            end
            if (w_load_skid) begin
                r_skid_data <= w_sel_data;
                r_skid_err  <= w_sel_err;
            end
            if (w_accept && w_sel_err && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = (r_state != ST_EMPTY);
    assign out_data    = r_main_data;
    assign out_sel_err = r_main_err;
    assign err_cnt     = r_err_cnt;

endmodule

`default_nettype wire

// File: doc/pipe_mux_n.md
PIPE_MUX_N -- requirements
Module: pipe_mux_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning data bits per input channel.
REQ-002 The block SHALL have parameter N, default 4, meaning number of input channels, legal range 2..16.
REQ-003 The block SHALL have parameter SEL_W, default $clog2(N), meaning select width.
REQ-004 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, meaning synchronous active-high reset.
REQ-006 The block SHALL have port in_data, input, N*WIDTH bits, meaning channel k at bits [k*WIDTH +: WIDTH].
REQ-007 The block SHALL have port in_sel, input, SEL_W bits, meaning channel index.
REQ-008 The block SHALL have port in_valid, input, 1 bit, meaning upstream offers in_data/in_sel.
REQ-009 The block SHALL have port in_ready, output, 1 bit, meaning block can accept this cycle.
REQ-010 The block SHALL have port flush, input, 1 bit, meaning discard all buffered entries.
REQ-011 The block SHALL have port out_data, output, WIDTH bits, meaning selected channel data.
REQ-012 The block SHALL have port out_sel_err, output, 1 bit, meaning the out_data entry had an out-of-range select.
REQ-013 The block SHALL have port out_valid, output, 1 bit, meaning out_data/out_sel_err are valid.
REQ-014 The block SHALL have port out_ready, input, 1 bit, meaning downstream accepts.
REQ-015 The block SHALL have port err_cnt, output, 8 bits, meaning saturating count of accepted out-of-range selects.

Function
REQ-016 Accept SHALL occur iff in_valid && in_ready; drain SHALL occur iff out_valid && out_ready.
REQ-017 Selection SHALL be out = channel[in_sel] when in_sel < N; otherwise out = channel 0 with sel_err = 1.
REQ-018 The selected data and sel_err SHALL be captured at accept; the selection is not re-evaluated later.
REQ-019 The block SHALL be a 2-entry skid buffer (main, skid) with states EMPTY, ONE, TWO.
REQ-020 EMPTY: accept -> ONE; otherwise stay.
REQ-021 ONE: accept without drain -> TWO (entry to skid); drain without accept -> EMPTY; accept with drain -> ONE (new entry to main).
REQ-022 TWO: drain -> ONE (skid moves to main); no accept is possible in TWO.
REQ-023 in_ready SHALL be a registered output, high in EMPTY and ONE, low in TWO; it SHALL NOT depend combinationally on out_ready.
REQ-024 out_valid SHALL be high in ONE and TWO; out_data/out_sel_err SHALL always present the main entry.
REQ-025 Latency SHALL be 1 cycle from accept to out_valid when EMPTY; throughput SHALL be 1 per cycle with out_ready held high.
REQ-026 Ordering SHALL be FIFO; no entry SHALL be dropped or duplicated except by flush or rst.
REQ-027 While out_valid && !out_ready, out_data and out_sel_err SHALL hold stable.
REQ-028 flush SHALL move the block to EMPTY on the next edge; any accept or drain in the flush cycle SHALL be discarded, and err_cnt SHALL still count accepts in that cycle.
REQ-029 err_cnt SHALL increment by 1 on each accept with sel_err = 1 and saturate at 255; flush SHALL NOT clear it.
REQ-030 When N is a power of two, sel_err SHALL be constant 0.

Reset
REQ-031 rst SHALL force state EMPTY, out_valid = 0, in_ready = 1, out_data = 0, out_sel_err = 0, and err_cnt = 0 on the next edge.
REQ-032 rst SHALL take priority over flush and any handshake in the same cycle, including mid-stream in state TWO.

Verification
REQ-033 WIDTH=32, N=4, channels {0x11,0x22,0x33,0x44}, sel=2, accept into EMPTY, out_ready=1 -> next cycle out_valid=1, out_data=0x33.
REQ-034 N=5, sel=7 accepted with ch0=0xAAAA -> out_data=0xAAAA, out_sel_err=1, err_cnt 0->1; 300 such accepts -> err_cnt=255.
REQ-035 out_ready=0; accept A=0x1, then B=0x2 -> in_ready=0 after the second accept; then out_ready=1 -> outputs 0x1 then 0x2 on consecutive cycles, in_ready=1 after the first drain.
REQ-036 Continuous in_valid=1, out_ready=1, values 1..100 -> 100 outputs in order, one per cycle, no bubbles after the first.
REQ-037 State TWO, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1; flushed and same-cycle data are never output.
REQ-038 State TWO, assert rst and flush together -> next cycle all outputs at reset values, err_cnt=0.
